// File: rtl/life_pkg.sv
// Shared constants and state encoding for the life-grid datapath.
package life_pkg;

    localparam int DEF_ROW_LENGTH = 1280;
    localparam int DEF_NUM_ROWS   = 720;
    localparam int ROW_ADDR_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } lb_state_t;

endpackage

// File: rtl/row_window.sv
// Three-row vertical shift register with clear, shift and zero-insert controls.
module row_window
    import life_pkg::*;
#(
    parameter int ROW_LENGTH = DEF_ROW_LENGTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift,
    input  logic                  zero_in,
    input  logic [ROW_LENGTH-1:0] din,
    output logic [ROW_LENGTH-1:0] top_row,
    output logic [ROW_LENGTH-1:0] middle_row,
    output logic [ROW_LENGTH-1:0] bottom_row
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            top_row    <= '0;
            middle_row <= '0;
            bottom_row <= '0;
        end else if (shift) begin
            top_row    <= middle_row;
            middle_row <= bottom_row;
            bottom_row <= zero_in ? '0 : din;
        end
    end

endmodule

// File: rtl/line_buffer.sv
// Streams every BRAM row through a three-row window, one neighbourhood per cycle,
// with zero rows above row 0 and below the last row.
module line_buffer
    import life_pkg::*;
#(
    parameter int ROW_LENGTH = DEF_ROW_LENGTH,
    parameter int NUM_ROWS   = DEF_NUM_ROWS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ROW_ADDR_W-1:0] rd_addr,
    input  logic [ROW_LENGTH-1:0] rd_data,
    output logic [ROW_LENGTH-1:0] top_row,
    output logic [ROW_LENGTH-1:0] middle_row,
    output logic [ROW_LENGTH-1:0] bottom_row,
    output logic [ROW_ADDR_W-1:0] calc_row_in,
    output logic                  calc_flg,
    output logic                  valid_set,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(NUM_ROWS - 1);

    lb_state_t             state, state_nxt;
    logic                  rd_valid;
    logic                  fill_half;
    logic                  start_acc;
    logic                  win_clear;
    logic                  win_shift;
    logic                  win_zero;
    logic [ROW_ADDR_W-1:0] calc_row;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // The zero-insert shift happens on the last RUN cycle (first cycle with no
    // read data), so FLUSH is the cycle that presents the final row.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        win_clear = 1'b0;
        win_shift = 1'b0;
        win_zero  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    win_clear = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (rd_valid) begin
                    win_shift = 1'b1;
                    if (fill_half) state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                win_shift = 1'b1;
                if (!rd_valid) begin
                    win_zero  = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Marks that row 0 has been captured while filling.
    always_ff @(posedge clk) begin
        if (rst || state != ST_FILL) fill_half <= 1'b0;
        else if (rd_valid)           fill_half <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (start_acc) begin
                rd_en   <= 1'b1;
                rd_addr <= '0;
            end else if (rd_en) begin
                if (rd_addr == LAST_ROW) begin
                    rd_en   <= 1'b0;
                    rd_addr <= '0;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc)    calc_row <= '0;
        else if (state == ST_RUN) calc_row <= calc_row + 1'b1;
    end

    row_window #(
        .ROW_LENGTH(ROW_LENGTH)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .clear     (win_clear),
        .shift     (win_shift),
        .zero_in   (win_zero),
        .din       (rd_data),
        .top_row   (top_row),
        .middle_row(middle_row),
        .bottom_row(bottom_row)
    );

    assign busy        = (state == ST_FILL) || (state == ST_RUN) || (state == ST_FLUSH);
    assign calc_flg    = busy;
    assign valid_set   = (state == ST_RUN) || (state == ST_FLUSH);
    assign done        = (state == ST_DONE);
    assign calc_row_in = valid_set ? calc_row : '0;

endmodule

// File: tb/tb_line_buffer.sv
// Scoreboard bench for line_buffer: NUM_ROWS=4 and NUM_ROWS=2 instances, 8-bit rows.
module tb_line_buffer;

    typedef struct {
        int unsigned c;
        logic [7:0]  t;
        logic [7:0]  m;
        logic [7:0]  b;
        logic [9:0]  r;
    } win_t;

    typedef struct {
        int unsigned c;
        logic [9:0]  a;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic rst, start, start2;

    logic       rd_en, calc_flg, valid_set, busy, done;
    logic [9:0] rd_addr, calc_row_in;
    logic [7:0] rd_data, top_row, middle_row, bottom_row;

    logic       rd_en2, calc_flg2, valid_set2, busy2, done2;
    logic [9:0] rd_addr2, calc_row_in2;
    logic [7:0] rd_data2, top_row2, middle_row2, bottom_row2;

    logic [7:0] mem  [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    logic [7:0] mem2 [2] = '{8'hF0, 8'h0F};

    // Hand-computed windows for rows {A5,3C,FF,01}: cycles 4..7
    win_t exp4 [4] = '{
        '{4, 8'h00, 8'hA5, 8'h3C, 10'd0},
        '{5, 8'hA5, 8'h3C, 8'hFF, 10'd1},
        '{6, 8'h3C, 8'hFF, 8'h01, 10'd2},
        '{7, 8'hFF, 8'h01, 8'h00, 10'd3}
    };
    win_t exp2 [2] = '{
        '{4, 8'h00, 8'hF0, 8'h0F, 10'd0},
        '{5, 8'hF0, 8'h0F, 8'h00, 10'd1}
    };

    win_t        wq[$],  wq2[$];
    rd_t         rq[$],  rq2[$];
    int unsigned dq[$],  dq2[$];

    always @(posedge clk) if (rd_en  && rd_addr  < 10'd4) rd_data  <= mem[rd_addr[1:0]];
    always @(posedge clk) if (rd_en2 && rd_addr2 < 10'd2) rd_data2 <= mem2[rd_addr2[0]];

    line_buffer #(.ROW_LENGTH(8), .NUM_ROWS(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .top_row(top_row), .middle_row(middle_row), .bottom_row(bottom_row),
        .calc_row_in(calc_row_in), .calc_flg(calc_flg), .valid_set(valid_set),
        .busy(busy), .done(done)
    );

    line_buffer #(.ROW_LENGTH(8), .NUM_ROWS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .top_row(top_row2), .middle_row(middle_row2), .bottom_row(bottom_row2),
        .calc_row_in(calc_row_in2), .calc_flg(calc_flg2), .valid_set(valid_set2),
        .busy(busy2), .done(done2)
    );

    // Monitor for the 4-row instance
    always @(negedge clk) begin
        win_t w;
        rd_t  r;
        if (rq.size() > 0 && rq[0].c < cyc) begin
            checks++; errors++;
            $display("FAIL rd_missing cyc=%0d exp_addr=%0d at cyc %0d", cyc, rq[0].a, rq[0].c);
            void'(rq.pop_front());
        end
        if (wq.size() > 0 && wq[0].c < cyc) begin
            checks++; errors++;
            $display("FAIL win_missing cyc=%0d exp_row=%0d at cyc %0d", cyc, wq[0].r, wq[0].c);
            void'(wq.pop_front());
        end
        if (dq.size() > 0 && dq[0] < cyc) begin
            checks++; errors++;
            $display("FAIL done_missing cyc=%0d exp at cyc %0d", cyc, dq[0]);
            void'(dq.pop_front());
        end
        if (rd_en) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected cyc=%0d got_addr=%0d exp none", cyc, rd_addr);
            end else begin
                r = rq.pop_front();
                if (r.c != cyc || r.a !== rd_addr) begin
                    errors++;
                    $display("FAIL rd cyc=%0d got_addr=%0d exp_addr=%0d exp_cyc=%0d", cyc, rd_addr, r.a, r.c);
                end
            end
        end
        if (valid_set) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL win_unexpected cyc=%0d got_row=%0d exp none", cyc, calc_row_in);
            end else begin
                w = wq.pop_front();
                if (w.c != cyc || w.t !== top_row || w.m !== middle_row ||
                    w.b !== bottom_row || w.r !== calc_row_in) begin
                    errors++;
                    $display("FAIL win cyc=%0d got=(%h,%h,%h,%0d) exp=(%h,%h,%h,%0d)@%0d", cyc,
                             top_row, middle_row, bottom_row, calc_row_in, w.t, w.m, w.b, w.r, w.c);
                end
            end
        end else begin
            checks++;
            if (calc_row_in !== 10'd0) begin
                errors++;
                $display("FAIL calc_row_idle cyc=%0d got=%0d exp=0", cyc, calc_row_in);
            end
        end
        if (done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
            end else if (dq.pop_front() != cyc) begin
                errors++;
                $display("FAIL done_timing cyc=%0d got=1 exp at other cycle", cyc);
            end
        end
    end

    // Monitor for the 2-row instance
    always @(negedge clk) begin
        win_t w;
        rd_t  r;
        if (rq2.size() > 0 && rq2[0].c < cyc) begin
            checks++; errors++;
            $display("FAIL rd2_missing cyc=%0d exp_addr=%0d", cyc, rq2[0].a);
            void'(rq2.pop_front());
        end
        if (wq2.size() > 0 && wq2[0].c < cyc) begin
            checks++; errors++;
            $display("FAIL win2_missing cyc=%0d exp_row=%0d", cyc, wq2[0].r);
            void'(wq2.pop_front());
        end
        if (dq2.size() > 0 && dq2[0] < cyc) begin
            checks++; errors++;
            $display("FAIL done2_missing cyc=%0d exp at cyc %0d", cyc, dq2[0]);
            void'(dq2.pop_front());
        end
        if (rd_en2) begin
            checks++;
            if (rq2.size() == 0) begin
                errors++;
                $display("FAIL rd2_unexpected cyc=%0d got_addr=%0d exp none", cyc, rd_addr2);
            end else begin
                r = rq2.pop_front();
                if (r.c != cyc || r.a !== rd_addr2) begin
                    errors++;
                    $display("FAIL rd2 cyc=%0d got_addr=%0d exp_addr=%0d exp_cyc=%0d", cyc, rd_addr2, r.a, r.c);
                end
            end
        end
        if (valid_set2) begin
            checks++;
            if (wq2.size() == 0) begin
                errors++;
                $display("FAIL win2_unexpected cyc=%0d got_row=%0d exp none", cyc, calc_row_in2);
            end else begin
                w = wq2.pop_front();
                if (w.c != cyc || w.t !== top_row2 || w.m !== middle_row2 ||
                    w.b !== bottom_row2 || w.r !== calc_row_in2) begin
                    errors++;
                    $display("FAIL win2 cyc=%0d got=(%h,%h,%h,%0d) exp=(%h,%h,%h,%0d)@%0d", cyc,
                             top_row2, middle_row2, bottom_row2, calc_row_in2, w.t, w.m, w.b, w.r, w.c);
                end
            end
        end
        if (done2) begin
            checks++;
            if (dq2.size() == 0 || dq2.pop_front() != cyc) begin
                errors++;
                $display("FAIL done2 cyc=%0d got=1 exp=0", cyc);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int unsigned hold, output int unsigned t0);
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 4; k++) rq.push_back('{t0 + 1 + k, 10'(k)});
        for (int k = 0; k < 4; k++) wq.push_back('{t0 + exp4[k].c, exp4[k].t, exp4[k].m, exp4[k].b, exp4[k].r});
        dq.push_back(t0 + 8);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int unsigned t0, t1;
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_outputs", 64'({rd_en, rd_addr, top_row, middle_row, bottom_row,
                                    calc_row_in, calc_flg, valid_set, busy, done}), 64'd0);

        // Basic pass with busy/done timing
        issue(1, t0);
        check("busy_c1", 64'({busy, calc_flg}), 64'b11);
        wait_until(t0 + 7);
        check("busy_c7", 64'({busy, calc_flg}), 64'b11);
        wait_until(t0 + 8);
        check("done_c8", 64'({busy, calc_flg, done}), 64'b001);
        wait_until(t0 + 9);
        check("idle_c9", 64'({busy, done, rd_en}), 64'd0);
        wait_until(t0 + 10);

        // start held through the done cycle: exactly one pass
        issue(9, t0);
        wait_until(t0 + 14);
        check("hold_no_rerun", 64'({rd_en, busy}), 64'd0);

        // Reset in cycle 5 of a pass
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 4; k++) rq.push_back('{t0 + 1 + k, 10'(k)});
        for (int k = 0; k < 2; k++) wq.push_back('{t0 + exp4[k].c, exp4[k].t, exp4[k].m, exp4[k].b, exp4[k].r});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_until(t0 + 5);
        rst = 1'b1;
        wait_until(t0 + 6);
        check("rst_outputs", 64'({rd_en, rd_addr, top_row, middle_row, bottom_row,
                                  calc_row_in, calc_flg, valid_set, busy, done}), 64'd0);
        rst = 1'b0;
        wait_until(t0 + 12);
        check("rst_quiet", 64'({rd_en, busy}), 64'd0);

        // Fresh pass after reset, then back-to-back passes
        issue(1, t0);
        wait_until(t0 + 10);
        issue(1, t0);
        wait_until(t0 + 8);
        issue(1, t1);
        check("b2b_c1", 64'({busy, rd_en, rd_addr}), 64'({1'b1, 1'b1, 10'd0}));
        wait_until(t1 + 10);

        // Two-row grid
        @(posedge clk);
        #1;
        start2 = 1'b1;
        t0 = cyc;
        rq2.push_back('{t0 + 1, 10'd0});
        rq2.push_back('{t0 + 2, 10'd1});
        for (int k = 0; k < 2; k++) wq2.push_back('{t0 + exp2[k].c, exp2[k].t, exp2[k].m, exp2[k].b, exp2[k].r});
        dq2.push_back(t0 + 6);
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("n2_busy_c1", 64'({busy2, calc_flg2}), 64'b11);
        wait_until(t0 + 7);
        check("n2_idle_c7", 64'({busy2, calc_flg2, done2, valid_set2}), 64'd0);
        wait_until(t0 + 9);

        check("queues_drained", 64'(rq.size() + wq.size() + dq.size() +
                                    rq2.size() + wq2.size() + dq2.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

endmodule
